bias_startup_ctrl: RTL and testbench
====================================

Name: bias_startup_ctrl

Overview:
- Digital sequencer directly upstream of the EG1D80V bias/bandgap IO cell; drives the cell's EN_I, BG_STARTUP_I, EN_VBIAS_I and TRIM_* pins and consumes its BG_VALID_N_O.
- Performs the power-up sequence: enable, timed startup pulse, settle wait, and valid check with timeout and retry.
- Holds trim codes in shadow registers and reports READY/FAULT to the always-on control domain.

Parameters:
- STARTUP_CYCLES, 16: exact number of cycles BG_STARTUP_O is high per attempt; must be >=1.
- SETTLE_CYCLES, 64: cycles after startup deassertion before valid is sampled; must be >=1.
- TIMEOUT_CYCLES, 256: maximum cycles in WAIT_VALID before a retry; must be >=1.
- MAX_RETRIES, 3: number of retries after the first attempt before FAULT.
- TRIM_BIAS_RST, 4'h8: reset value of TRIM_BIAS_O.
- TRIM_CURV_RST, 5'h10: reset value of TRIM_CURV_O.
- TRIM_VBG_RST, 5'h10: reset value of TRIM_VBG_O.

Ports:
- CLK_I  in  1  block clock.
- RST_I  in  1  synchronous, active-high reset.
- REQ_EN_I  in  1  level request for bias on.
- REQ_VBIAS_I  in  1  level request to drive VBIAS once READY.
- TRIM_LOAD_I  in  1  single-cycle strobe to capture the *_CFG_I inputs.
- TRIM_BIAS_CFG_I  in  4  trim value to load into TRIM_BIAS_O.
- TRIM_CURV_CFG_I  in  5  trim value to load into TRIM_CURV_O.
- TRIM_VBG_CFG_I  in  5  trim value to load into TRIM_VBG_O.
- BG_VALID_N_I  in  1  from the cell's BG_VALID_N_O; asynchronous.
- EN_O  out  1  to the cell's EN_I.
- BG_STARTUP_O  out  1  to the cell's BG_STARTUP_I.
- EN_VBIAS_O  out  1  to the cell's EN_VBIAS_I.
- TRIM_BIAS_O  out  4  to the cell's TRIM_BIAS_I.
- TRIM_CURV_O  out  5  to the cell's TRIM_CURV_I.
- TRIM_VBG_O  out  5  to the cell's TRIM_VBG_I.
- READY_O  out  1  bandgap valid and sequence complete.
- FAULT_O  out  1  sticky failure after retries are exhausted.
- STATE_O  out  3  current FSM state encoding.
- RETRY_CNT_O  out  2  retries used in the current power-up.

Interface rule: one clock; reset is synchronous and active-high (CLK_I, RST_I).

Behaviour:
- Reset values:
  - State OFF; EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, FAULT_O = 0.
  - TRIM_* = *_RST parameters; RETRY_CNT_O = 0; counter = 0; trim-pending flag = 0.
  - Synchronizer flops reset to 1 (invalid).
- BG_VALID_N_I passes through a 2-flop synchronizer, giving 2 cycles of latency. The FSM uses only the synchronized signal valid_s = !sync_out.
- All outputs are registered.
- State encoding: OFF=0, STARTUP=1, SETTLE=2, WAIT_VALID=3, READY=4, FAULT=5.
- OFF:
  - All enables are 0.
  - REQ_EN_I=1 -> STARTUP; load counter with STARTUP_CYCLES-1; RETRY_CNT_O=0.
- STARTUP:
  - EN_O=1, BG_STARTUP_O=1.
  - When counter reaches 0 -> SETTLE; load counter with SETTLE_CYCLES-1.
  - BG_STARTUP_O is high exactly STARTUP_CYCLES cycles.
- SETTLE:
  - EN_O=1, BG_STARTUP_O=0.
  - When counter reaches 0 -> WAIT_VALID; load counter with TIMEOUT_CYCLES-1.
- WAIT_VALID:
  - valid_s=1 -> READY.
  - Otherwise, when counter reaches 0:
    - If RETRY_CNT_O < MAX_RETRIES: increment RETRY_CNT_O, -> STARTUP (EN_O stays 1).
    - Else -> FAULT.
  - If valid_s and timeout occur in the same cycle, valid wins.
- READY:
  - READY_O=1; EN_VBIAS_O=REQ_VBIAS_I, registered with 1-cycle latency.
  - If valid_s falls: READY_O=0 and EN_VBIAS_O=0 the next cycle, then follow the same retry/FAULT rule as a timeout.
- FAULT:
  - FAULT_O=1; EN_O, BG_STARTUP_O, EN_VBIAS_O = 0.
  - Exit only via REQ_EN_I=0 -> OFF.
- REQ_EN_I=0 in any state -> OFF on the next edge. This has priority over every other transition.
  - On entering OFF, FAULT_O and RETRY_CNT_O clear.
- EN_VBIAS_O is 0 in every state except READY.
- Trim:
  - TRIM_LOAD_I in OFF or READY: capture into TRIM_* on the next edge.
  - TRIM_LOAD_I in STARTUP, SETTLE, WAIT_VALID or FAULT: latch into a pending buffer and apply on the first cycle in OFF or READY.
  - A new load while pending overwrites the buffer; last value wins.
- RST_I mid-sequence returns all registers to reset values in one cycle. There is no glitch on EN_O beyond that edge.
- RETRY_CNT_O width is fixed at 2 bits; MAX_RETRIES > 3 is illegal and is checked by an elaboration assertion.
- The counter width is $clog2 of the largest cycle parameter plus 1.

Decomposition:
- Package bias_ctrl_pkg holds:
  - the state enum bias_state_e (3 bits);
  - TRIM_BIAS_W=4 and TRIM_CURV_W = TRIM_VBG_W = 5;
  - a trim struct trim_cfg_t.
- One sub-module, bias_sync_2ff: 2-flop synchronizer with a reset-value parameter (RST_VAL=1 here).

Test Plan:
- Nominal power-up:
  - Stimulus: REQ_EN_I=1; BG_VALID_N_I=0 from t=0; defaults.
  - Response: BG_STARTUP_O high exactly 16 cycles; READY_O rises at cycle 1+16+64+1+sync latency (within 2); EN_VBIAS_O follows REQ_VBIAS_I one cycle later.
- Timeout with recovery:
  - Stimulus: BG_VALID_N_I=1 for the first two attempts, 0 from the third.
  - Response: RETRY_CNT_O=2; READY_O=1; FAULT_O=0.
- Fault:
  - Stimulus: BG_VALID_N_I held at 1.
  - Response: 4 startup pulses, then FAULT_O=1 and EN_O=0.
  - Then REQ_EN_I=0 -> FAULT_O=0 and STATE_O=0 one cycle later.
- Trim deferral:
  - Stimulus: TRIM_LOAD_I with VBG_CFG=5'h03 during SETTLE.
  - Response: TRIM_VBG_O stays 5'h10 until the first READY cycle, then 5'h03.
  - A load of 5'h07 in READY appears on the next edge.
- Valid loss:
  - Stimulus: in READY, BG_VALID_N_I=1 for 300 cycles.
  - Response: READY_O and EN_VBIAS_O drop within 3 cycles; retry restarts STARTUP; RETRY_CNT_O=1.
- Abort and reset:
  - Stimulus: REQ_EN_I=0 mid-STARTUP.
  - Response: next cycle EN_O=0, BG_STARTUP_O=0, STATE_O=0.
  - RST_I pulse in READY -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/bias_startup_ctrl_pkg.sv
// Shared types, widths and helpers for the bias/bandgap startup controller.
package bias_ctrl_pkg;

    localparam int unsigned TRIM_BIAS_W = 4;
    localparam int unsigned TRIM_CURV_W = 5;
    localparam int unsigned TRIM_VBG_W  = 5;

    // Encoding is visible on STATE_O, so the values are pinned.
    typedef enum logic [2:0] {
        StOff       = 3'd0,
        StStartup   = 3'd1,
        StSettle    = 3'd2,
        StWaitValid = 3'd3,
        StReady     = 3'd4,
        StFault     = 3'd5
    } bias_state_e;

    typedef struct packed {
        logic [TRIM_BIAS_W-1:0] bias;
        logic [TRIM_CURV_W-1:0] curv;
        logic [TRIM_VBG_W-1:0]  vbg;
    } trim_cfg_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/bias_startup_ctrl_if.sv
// Control-domain and IO-cell signals of the bias startup controller.
// master: the environment (always-on domain plus the cell); slave: the controller.
interface bias_startup_ctrl_if;
    import bias_ctrl_pkg::*;

    logic                   REQ_EN_I;
    logic                   REQ_VBIAS_I;
    logic                   TRIM_LOAD_I;
    logic [TRIM_BIAS_W-1:0] TRIM_BIAS_CFG_I;
    logic [TRIM_CURV_W-1:0] TRIM_CURV_CFG_I;
    logic [TRIM_VBG_W-1:0]  TRIM_VBG_CFG_I;
    logic                   BG_VALID_N_I;
    logic                   EN_O;
    logic                   BG_STARTUP_O;
    logic                   EN_VBIAS_O;
    logic [TRIM_BIAS_W-1:0] TRIM_BIAS_O;
    logic [TRIM_CURV_W-1:0] TRIM_CURV_O;
    logic [TRIM_VBG_W-1:0]  TRIM_VBG_O;
    logic                   READY_O;
    logic                   FAULT_O;
    logic [2:0]             STATE_O;
    logic [1:0]             RETRY_CNT_O;

    modport master (
        output REQ_EN_I, REQ_VBIAS_I, TRIM_LOAD_I,
        output TRIM_BIAS_CFG_I, TRIM_CURV_CFG_I, TRIM_VBG_CFG_I, BG_VALID_N_I,
        input  EN_O, BG_STARTUP_O, EN_VBIAS_O, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O,
        input  READY_O, FAULT_O, STATE_O, RETRY_CNT_O
    );

    modport slave (
        input  REQ_EN_I, REQ_VBIAS_I, TRIM_LOAD_I,
        input  TRIM_BIAS_CFG_I, TRIM_CURV_CFG_I, TRIM_VBG_CFG_I, BG_VALID_N_I,
        output EN_O, BG_STARTUP_O, EN_VBIAS_O, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O,
        output READY_O, FAULT_O, STATE_O, RETRY_CNT_O
    );

endinterface

// File: rtl/bias_startup_ctrl_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module bias_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bias_startup_ctrl.sv
// Power-up sequencer for the bias/bandgap IO cell: enable, timed startup pulse,
// settle, valid check with timeout/retry, plus shadowed trim codes.
module bias_startup_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int unsigned            STARTUP_CYCLES = 16,
    parameter int unsigned            SETTLE_CYCLES  = 64,
    parameter int unsigned            TIMEOUT_CYCLES = 256,
    parameter int unsigned            MAX_RETRIES    = 3,
    parameter logic [TRIM_BIAS_W-1:0] TRIM_BIAS_RST  = 4'h8,
    parameter logic [TRIM_CURV_W-1:0] TRIM_CURV_RST  = 5'h10,
    parameter logic [TRIM_VBG_W-1:0]  TRIM_VBG_RST   = 5'h10
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    bias_startup_ctrl_if.slave  bus
);

    localparam int unsigned CntMax = max3(STARTUP_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [CntW-1:0] StartupLoad = CntW'(STARTUP_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      RetryMax    = 2'(MAX_RETRIES);

    localparam trim_cfg_t TrimRst = '{bias: TRIM_BIAS_RST, curv: TRIM_CURV_RST,
                                      vbg: TRIM_VBG_RST};

    if (MAX_RETRIES > 3) begin : g_bad_retries
        $error("MAX_RETRIES must not exceed 3 (RETRY_CNT_O is 2 bits)");
    end
    if (STARTUP_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("cycle parameters must be at least 1");
    end

    bias_state_e      state_q;
    logic [CntW-1:0]  cnt_q;
    logic [1:0]       retry_q;
    logic             en_q;
    logic             bg_startup_q;
    logic             en_vbias_q;
    logic             ready_q;
    logic             fault_q;
    trim_cfg_t        trim_q;
    trim_cfg_t        pend_buf_q;
    logic             pend_q;

    logic             sync_out;
    logic             valid_s;
    logic             retry_ok;
    logic             trim_apply_ok;
    trim_cfg_t        trim_cfg;

    bias_sync_2ff #(
        .RST_VAL (1'b1)
    ) u_valid_sync (
        .clk_i (CLK_I),
        .rst_i (RST_I),
        .d_i   (bus.BG_VALID_N_I),
        .q_o   (sync_out)
    );

    assign valid_s       = ~sync_out;
    assign retry_ok      = (retry_q < RetryMax);
    assign trim_apply_ok = (state_q == StOff) || (state_q == StReady);
    assign trim_cfg      = '{bias: bus.TRIM_BIAS_CFG_I, curv: bus.TRIM_CURV_CFG_I,
                             vbg: bus.TRIM_VBG_CFG_I};

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            retry_q      <= '0;
            en_q         <= 1'b0;
            bg_startup_q <= 1'b0;
            en_vbias_q   <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else if (!bus.REQ_EN_I) begin
            // Dropping the request aborts from anywhere and clears fault/retry history.
            state_q      <= StOff;
            cnt_q        <= '0;
            retry_q      <= '0;
            en_q         <= 1'b0;
            bg_startup_q <= 1'b0;
            en_vbias_q   <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_q      <= StStartup;
                    cnt_q        <= StartupLoad;
                    retry_q      <= '0;
                    en_q         <= 1'b1;
                    bg_startup_q <= 1'b1;
                end
                StStartup: begin
                    if (cnt_q == '0) begin
                        state_q      <= StSettle;
                        cnt_q        <= SettleLoad;
                        bg_startup_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_q <= StWaitValid;
                        cnt_q   <= TimeoutLoad;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StWaitValid: begin
                    // Valid is checked first so it wins over a simultaneous timeout.
                    if (valid_s) begin
                        state_q    <= StReady;
                        ready_q    <= 1'b1;
                        en_vbias_q <= 1'b0;
                    end else if (cnt_q == '0) begin
                        if (retry_ok) begin
                            state_q      <= StStartup;
                            cnt_q        <= StartupLoad;
                            retry_q      <= retry_q + 2'd1;
                            bg_startup_q <= 1'b1;
                        end else begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                            en_q    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StReady: begin
                    if (!valid_s) begin
                        ready_q    <= 1'b0;
                        en_vbias_q <= 1'b0;
                        if (retry_ok) begin
                            state_q      <= StStartup;
                            cnt_q        <= StartupLoad;
                            retry_q      <= retry_q + 2'd1;
                            bg_startup_q <= 1'b1;
                        end else begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                            en_q    <= 1'b0;
                        end
                    end else begin
                        en_vbias_q <= bus.REQ_VBIAS_I;
                    end
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q      <= StOff;
                    cnt_q        <= '0;
                    en_q         <= 1'b0;
                    bg_startup_q <= 1'b0;
                    en_vbias_q   <= 1'b0;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

    // Trim shadow: direct load in OFF/READY, otherwise buffered until OFF/READY.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            trim_q     <= TrimRst;
            pend_buf_q <= TrimRst;
            pend_q     <= 1'b0;
        end else if (bus.TRIM_LOAD_I) begin
            if (trim_apply_ok) begin
                trim_q <= trim_cfg;
                pend_q <= 1'b0;
            end else begin
                pend_buf_q <= trim_cfg;
                pend_q     <= 1'b1;
            end
        end else if (pend_q && trim_apply_ok) begin
            trim_q <= pend_buf_q;
            pend_q <= 1'b0;
        end
    end

    assign bus.EN_O         = en_q;
    assign bus.BG_STARTUP_O = bg_startup_q;
    assign bus.EN_VBIAS_O   = en_vbias_q;
    assign bus.READY_O      = ready_q;
    assign bus.FAULT_O      = fault_q;
    assign bus.STATE_O      = state_q;
    assign bus.RETRY_CNT_O  = retry_q;
    assign bus.TRIM_BIAS_O  = trim_q.bias;
    assign bus.TRIM_CURV_O  = trim_q.curv;
    assign bus.TRIM_VBG_O   = trim_q.vbg;

endmodule

// File: tb/tb_bias_startup_ctrl.sv
// Self-checking bench for bias_startup_ctrl with a timeline-level reference model.
module tb_bias_startup_ctrl;

    localparam int S  = 16;
    localparam int T  = 64;
    localparam int TO = 256;
    localparam int MR = 3;
    localparam int P  = S + T + TO;   // edges per attempt
    localparam int NEVER = 1 << 30;
    localparam logic [13:0] TRIM_RST = {4'h8, 5'h10, 5'h10};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bias_startup_ctrl_if bus ();

    bias_startup_ctrl #(
        .STARTUP_CYCLES (S),
        .SETTLE_CYCLES  (T),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR),
        .TRIM_BIAS_RST  (4'h8),
        .TRIM_CURV_RST  (5'h10),
        .TRIM_VBG_RST   (5'h10)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {EN, BG_STARTUP, READY, FAULT, STATE[2:0], RETRY[1:0]}
    function automatic logic [8:0] obs9();
        return {bus.EN_O, bus.BG_STARTUP_O, bus.READY_O, bus.FAULT_O, bus.STATE_O,
                bus.RETRY_CNT_O};
    endfunction

    function automatic logic [13:0] trims();
        return {bus.TRIM_BIAS_O, bus.TRIM_CURV_O, bus.TRIM_VBG_O};
    endfunction

    // Edge n is the n-th clock edge after the request (edge 0 samples REQ_EN=1).
    // BG_VALID_N is 0 from edge v on; the FSM sees it two edges later.
    // Attempt i spans edges i*P .. i*P+P-1 and checks valid at edges i*P+S+T+1 .. (i+1)*P.
    function automatic void plan(input int v, output int r, output int f, output int nret);
        r = -1;
        f = -1;
        nret = 0;
        for (int i = 0; i <= MR; i++) begin
            for (int m = i * P + S + T + 1; m <= (i + 1) * P; m++) begin
                if (m - 2 >= v) begin
                    r = m;
                    nret = i;
                    return;
                end
            end
        end
        f = (MR + 1) * P;
        nret = MR;
    endfunction

    function automatic logic [8:0] expect_at(input int n, input int r, input int f,
                                             input int nret);
        int off;
        logic [2:0] st;
        if (r >= 0 && n >= r) return {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 2'(nret)};
        if (f >= 0 && n >= f) return {1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'(MR)};
        off = n % P;
        st = (off < S) ? 3'd1 : ((off < S + T) ? 3'd2 : 3'd3);
        return {1'b1, (off < S), 1'b0, 1'b0, st, 2'(n / P)};
    endfunction

    task automatic go_off(input logic vn);
        bus.REQ_EN_I = 1'b0;
        bus.BG_VALID_N_I = vn;
        repeat (4) tick();
    endtask

    task automatic run_powerup(input string name, input int v, input int tail);
        int r, f, nret, last;
        logic pr, vb, env_exp;
        logic [8:0] e;
        plan(v, r, f, nret);
        go_off((v <= 0) ? 1'b0 : 1'b1);
        bus.REQ_EN_I = 1'b1;
        last = (r >= 0) ? r + tail : f + tail;
        pr = 1'b0;
        for (int n = 0; n <= last; n++) begin
            bus.BG_VALID_N_I = (n >= v) ? 1'b0 : 1'b1;
            vb = 1'($urandom_range(1, 0));
            bus.REQ_VBIAS_I = vb;
            tick();
            e = expect_at(n, r, f, nret);
            env_exp = pr && e[6] && vb;
            total++;
            if ({obs9(), bus.EN_VBIAS_O} !== {e, env_exp}) begin
                bad++;
                $display("FAIL %s v=%0d edge=%0d {en,bg,rdy,flt,st,rc,envb} got=%b want=%b",
                         name, v, n, {obs9(), bus.EN_VBIAS_O}, {e, env_exp});
                break;
            end
            pr = e[6];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.REQ_EN_I = 1'b0;
        bus.BG_VALID_N_I = 1'b1;
        repeat (3) tick();
        total++;
        if (obs9() !== 9'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b", obs9(), 9'd0);
        end
        total++;
        if (bus.EN_VBIAS_O !== 1'b0) begin
            bad++;
            $display("FAIL reset_envbias got=%b want=0", bus.EN_VBIAS_O);
        end
        total++;
        if (bus.TRIM_BIAS_O !== 4'h8) begin
            bad++;
            $display("FAIL reset_trim_bias got=%h want=8", bus.TRIM_BIAS_O);
        end
        total++;
        if (bus.TRIM_CURV_O !== 5'h10) begin
            bad++;
            $display("FAIL reset_trim_curv got=%h want=10", bus.TRIM_CURV_O);
        end
        total++;
        if (bus.TRIM_VBG_O !== 5'h10) begin
            bad++;
            $display("FAIL reset_trim_vbg got=%h want=10", bus.TRIM_VBG_O);
        end
        // Reset must dominate an active request.
        bus.REQ_EN_I = 1'b1;
        tick();
        total++;
        if (bus.STATE_O !== 3'd0) begin
            bad++;
            $display("FAIL reset_vs_req state got=%0d want=0", bus.STATE_O);
        end
        bus.REQ_EN_I = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal;
        run_powerup("nominal", 0, 20);
    endtask

    task automatic test_timeout_recovery;
        run_powerup("timeout_recovery", 2 * P + S + T - 1 + int'($urandom_range(TO - 1, 0)), 10);
    endtask

    task automatic test_valid_timeout_tie;
        run_powerup("valid_timeout_tie", P - 2, 10);
    endtask

    task automatic test_random;
        for (int k = 0; k < 3; k++) run_powerup("random", int'($urandom_range(4 * P, 0)), 8);
    endtask

    task automatic test_fault;
        run_powerup("fault", NEVER, 3);
        bus.REQ_EN_I = 1'b0;
        tick();
        total++;
        if ({bus.FAULT_O, bus.STATE_O, bus.RETRY_CNT_O, bus.EN_O} !== 7'd0) begin
            bad++;
            $display("FAIL fault_release {flt,st,rc,en} got=%b want=0",
                     {bus.FAULT_O, bus.STATE_O, bus.RETRY_CNT_O, bus.EN_O});
        end
    endtask

    task automatic test_trim;
        logic [13:0] a, b, c;
        int rc;
        logic got;
        a = {4'($urandom), 5'($urandom), 5'h1c};
        b = {4'($urandom), 5'($urandom), 5'h03};
        c = {4'($urandom), 5'($urandom), 5'h07};
        go_off(1'b0);
        bus.REQ_EN_I = 1'b1;
        rc = 0;
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            bus.TRIM_LOAD_I = (n == 10) || (n == 30);
            if (n == 10) {bus.TRIM_BIAS_CFG_I, bus.TRIM_CURV_CFG_I, bus.TRIM_VBG_CFG_I} = a;
            if (n == 30) {bus.TRIM_BIAS_CFG_I, bus.TRIM_CURV_CFG_I, bus.TRIM_VBG_CFG_I} = b;
            tick();
            bus.TRIM_LOAD_I = 1'b0;
            if (n == 40) begin
                total++;
                if (trims() !== TRIM_RST) begin
                    bad++;
                    $display("FAIL trim_deferred got=%h want=%h", trims(), TRIM_RST);
                end
            end
            if (bus.READY_O) begin
                rc++;
                if (rc == 2) begin
                    got = 1'b1;
                    total++;
                    if (trims() !== b) begin
                        bad++;
                        $display("FAIL trim_applied_in_ready got=%h want=%h", trims(), b);
                    end
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL trim_ready_timeout got=no_ready want=ready");
        end
        bus.TRIM_LOAD_I = 1'b1;
        {bus.TRIM_BIAS_CFG_I, bus.TRIM_CURV_CFG_I, bus.TRIM_VBG_CFG_I} = c;
        tick();
        bus.TRIM_LOAD_I = 1'b0;
        total++;
        if (trims() !== c) begin
            bad++;
            $display("FAIL trim_direct_load got=%h want=%h", trims(), c);
        end
    endtask

    task automatic test_valid_loss;
        logic seen;
        run_powerup("valid_loss_pre", 0, 5);
        bus.REQ_VBIAS_I = 1'b1;
        repeat (2) tick();
        total++;
        if (bus.EN_VBIAS_O !== 1'b1) begin
            bad++;
            $display("FAIL vbias_follow got=%b want=1", bus.EN_VBIAS_O);
        end
        bus.BG_VALID_N_I = 1'b1;
        repeat (2) tick();
        total++;
        if (bus.READY_O !== 1'b1) begin
            bad++;
            $display("FAIL loss_sync_latency ready got=%b want=1", bus.READY_O);
        end
        tick();
        total++;
        if ({obs9(), bus.EN_VBIAS_O} !== {9'b1_1_0_0_001_01, 1'b0}) begin
            bad++;
            $display("FAIL loss_drop {en,bg,rdy,flt,st,rc,envb} got=%b want=%b",
                     {obs9(), bus.EN_VBIAS_O}, {9'b1_1_0_0_001_01, 1'b0});
        end
        repeat (297) tick();
        total++;
        if ({bus.STATE_O, bus.RETRY_CNT_O} !== {3'd3, 2'd1}) begin
            bad++;
            $display("FAIL loss_waiting {st,rc} got=%b want=%b",
                     {bus.STATE_O, bus.RETRY_CNT_O}, {3'd3, 2'd1});
        end
        bus.BG_VALID_N_I = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            seen = bus.READY_O;
        end
        total++;
        if (!seen || bus.RETRY_CNT_O !== 2'd1 || bus.FAULT_O !== 1'b0) begin
            bad++;
            $display("FAIL loss_recover {ready,rc,flt} got=%b want=%b",
                     {seen, bus.RETRY_CNT_O, bus.FAULT_O}, 4'b1_01_0);
        end
    endtask

    task automatic test_abort;
        go_off(1'b0);
        bus.REQ_EN_I = 1'b1;
        repeat (int'($urandom_range(S - 2, 2))) tick();
        total++;
        if ({bus.STATE_O, bus.BG_STARTUP_O} !== {3'd1, 1'b1}) begin
            bad++;
            $display("FAIL abort_pre {st,bg} got=%b want=%b",
                     {bus.STATE_O, bus.BG_STARTUP_O}, 4'b001_1);
        end
        bus.REQ_EN_I = 1'b0;
        tick();
        total++;
        if ({bus.EN_O, bus.BG_STARTUP_O, bus.STATE_O} !== 5'd0) begin
            bad++;
            $display("FAIL abort {en,bg,st} got=%b want=0",
                     {bus.EN_O, bus.BG_STARTUP_O, bus.STATE_O});
        end
    endtask

    task automatic test_reset_in_ready;
        run_powerup("reset_pre", 0, 5);
        bus.REQ_VBIAS_I = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        total++;
        if ({obs9(), bus.EN_VBIAS_O, trims()} !== {9'd0, 1'b0, TRIM_RST}) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=%b",
                     {obs9(), bus.EN_VBIAS_O, trims()}, {9'd0, 1'b0, TRIM_RST});
        end
        rst = 1'b0;
        bus.REQ_EN_I = 1'b0;
        tick();
    endtask

    initial begin
        bus.REQ_EN_I = 1'b0;
        bus.REQ_VBIAS_I = 1'b0;
        bus.TRIM_LOAD_I = 1'b0;
        bus.TRIM_BIAS_CFG_I = '0;
        bus.TRIM_CURV_CFG_I = '0;
        bus.TRIM_VBG_CFG_I = '0;
        bus.BG_VALID_N_I = 1'b1;
        test_reset();
        test_nominal();
        test_timeout_recovery();
        test_valid_timeout_tie();
        test_random();
        test_fault();
        test_trim();
        test_valid_loss();
        test_abort();
        test_reset_in_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
